// File: rtl/array_scan_ctrl.sv
// array_scan_ctrl: scans enabled mic pairs through the correlator and streams one checksummed frame per scan
module array_scan_ctrl #(
  parameter int NPAIR = 4,
  parameter int ANG_W = 16,
  parameter logic [23:0] TO_CYC = 24'd6000000,
  parameter logic [7:0] HDR = 8'hA5,
  localparam int SW = NPAIR > 1 ? $clog2(NPAIR) : 1
) (
  input  logic             clk_60MHz,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             cfg_cont,
  input  logic [NPAIR-1:0] cfg_mask,
  output logic [SW-1:0]    pair_sel,
  output logic             meas_start,
  input  logic             meas_done,
  input  logic [ANG_W-1:0] meas_angle,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             to_err
);
  localparam int IW = $clog2(NPAIR + 1);
  localparam int NB = 3 + 2 * NPAIR;
  localparam int PW = $clog2(NB);
  typedef enum logic [2:0] {IDLE, SEL, START, WAIT, TX} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] pair_sel_q, pair_sel_d;
  logic meas_start_q, meas_start_d;
  logic [23:0] cnt_q, cnt_d;
  logic [NPAIR-1:0] status_q, status_d;
  logic [15:0] slot_q [NPAIR];
  logic [15:0] slot_d [NPAIR];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0] tx_data_q, tx_data_d, chk_q, chk_d;
  logic tx_valid_q, tx_valid_d, to_err_q, to_err_d, busy_q, busy_d;
  logic found;
  logic [SW-1:0] nxt_sel;
  logic [PW-1:0] nptr, off;
  logic [15:0] word;
  logic [7:0] nbyte;
  assign nptr = ptr_q + PW'(1);
  // lowest enabled pair at or above the current scan index
  always_comb begin
    found = 1'b0;
    nxt_sel = '0;
    for (int i = NPAIR - 1; i >= 0; i--)
      if (cfg_mask[i] && IW'(i) >= idx_q) begin
        found = 1'b1;
        nxt_sel = SW'(i);
      end
  end
  // frame byte following the current one; header is loaded directly at frame start
  always_comb begin
    off = nptr - PW'(2);
    word = '0;
    for (int i = 0; i < NPAIR; i++)
      if (off[PW-1:1] == (PW-1)'(i)) word = slot_q[i];
    nbyte = nptr == PW'(1) ? 8'(status_q) : nptr == PW'(NB - 1) ? chk_q : off[0] ? word[7:0] : word[15:8];
  end
  // scan sequencing, angle capture and frame transmission
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pair_sel_d = pair_sel_q;
    meas_start_d = 1'b0;
    cnt_d = cnt_q;
    status_d = status_q;
    slot_d = slot_q;
    ptr_d = ptr_q;
    tx_data_d = tx_data_q;
    tx_valid_d = tx_valid_q;
    chk_d = chk_q;
    to_err_d = to_err_q;
    case (state_q)
      IDLE: if (trig && cfg_mask != '0) begin
        state_d = SEL;
        idx_d = '0;
        status_d = '0;
      end
      SEL: begin
        for (int i = 0; i < NPAIR; i++)
          if (IW'(i) >= idx_q && (!found || SW'(i) < nxt_sel)) slot_d[i] = 16'h8000;
        if (found) begin
          state_d = START;
          pair_sel_d = nxt_sel;
        end else begin
          state_d = TX;
          tx_valid_d = 1'b1;
          tx_data_d = HDR;
          chk_d = HDR;
          ptr_d = '0;
        end
      end
      START: begin
        state_d = WAIT;
        meas_start_d = 1'b1;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 24'd1;
        if (meas_done || cnt_q == TO_CYC - 24'd1) begin
          slot_d[pair_sel_q] = meas_done ? 16'(signed'(meas_angle)) : 16'h8000;
          status_d[pair_sel_q] = !meas_done;
          to_err_d = to_err_q | !meas_done;
          idx_d = IW'(pair_sel_q) + IW'(1);
          state_d = SEL;
        end
      end
      TX: if (tx_valid_q && tx_ready) begin
        if (ptr_q == PW'(NB - 1)) begin
          tx_valid_d = 1'b0;
          state_d = cfg_cont ? SEL : IDLE;
          idx_d = '0;
          status_d = '0;
        end else begin
          ptr_d = nptr;
          tx_data_d = nbyte;
          chk_d = chk_q ^ nbyte;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and output registers
  always_ff @(posedge clk_60MHz)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      pair_sel_q <= '0;
      meas_start_q <= 1'b0;
      cnt_q <= '0;
      status_q <= '0;
      slot_q <= '{default: '0};
      ptr_q <= '0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      chk_q <= '0;
      to_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pair_sel_q <= pair_sel_d;
      meas_start_q <= meas_start_d;
      cnt_q <= cnt_d;
      status_q <= status_d;
      slot_q <= slot_d;
      ptr_q <= ptr_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      chk_q <= chk_d;
      to_err_q <= to_err_d;
      busy_q <= busy_d;
    end
  assign pair_sel = pair_sel_q;
  assign meas_start = meas_start_q;
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy = busy_q;
  assign to_err = to_err_q;
endmodule

// File: tb/tb_array_scan_ctrl.sv
// tb_array_scan_ctrl: directed and randomized checks of array_scan_ctrl against a frame-level model
module tb_array_scan_ctrl;
  localparam int NPAIR = 4;
  localparam int TO = 100;
  localparam int NB = 3 + 2 * NPAIR;
  logic clk = 1'b0, rst_n = 1'b0, trig = 1'b0, cfg_cont = 1'b0, meas_done = 1'b0, tx_ready = 1'b0;
  logic meas_start, tx_valid, busy, to_err;
  logic [3:0] cfg_mask = '0;
  logic [1:0] pair_sel;
  logic [15:0] meas_angle = '0;
  logic [7:0] tx_data;
  int checks = 0, errors = 0;
  int rdy_mode = 1;
  logic [15:0] ang [NPAIR];
  int dly [NPAIR];
  logic [7:0] rx [$];
  logic [7:0] exp_f [$];
  int visits [$];

  array_scan_ctrl #(.NPAIR(NPAIR), .ANG_W(16), .TO_CYC(24'd100), .HDR(8'hA5)) dut (
    .clk_60MHz(clk), .rst_n(rst_n), .trig(trig), .cfg_cont(cfg_cont), .cfg_mask(cfg_mask),
    .pair_sel(pair_sel), .meas_start(meas_start), .meas_done(meas_done), .meas_angle(meas_angle),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .to_err(to_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // expected frame: a pair times out when its done would arrive TO or more cycles after start
  function automatic void build();
    logic [7:0] st;
    logic [7:0] x;
    logic [15:0] s;
    st = '0;
    x = '0;
    exp_f = {};
    for (int i = 0; i < NPAIR; i++) if (cfg_mask[i] && dly[i] >= TO) st[i] = 1'b1;
    exp_f.push_back(8'hA5);
    exp_f.push_back(st);
    for (int i = 0; i < NPAIR; i++) begin
      s = (!cfg_mask[i] || dly[i] >= TO) ? 16'h8000 : ang[i];
      exp_f.push_back(s[15:8]);
      exp_f.push_back(s[7:0]);
    end
    foreach (exp_f[k]) x ^= exp_f[k];
    exp_f.push_back(x);
  endfunction

  // correlation subsystem stand-in: done arrives dly[pair] cycles after the start pulse is seen
  initial begin
    int rem, ps;
    bit act;
    rem = 0;
    ps = 0;
    act = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) act = 1'b0;
      else if (meas_start) begin
        ps = int'(pair_sel);
        visits.push_back(ps);
        act = 1'b1;
        rem = dly[ps];
      end
      if (act && rem == 0) begin
        meas_done = 1'b1;
        meas_angle = ang[ps];
        act = 1'b0;
      end else begin
        meas_done = 1'b0;
        meas_angle = 16'($urandom);
        if (act) rem--;
      end
    end
  end

  // UART stand-in: records accepted bytes and checks data holds while stalled
  initial begin
    bit pv, pr;
    logic [7:0] pd;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 1'b0;
      else if (pv && pr) rx.push_back(pd);
      else if (pv) begin
        chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_data", {24'd0, tx_data}, {24'd0, pd});
      end
      tx_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      pv = tx_valid && rst_n;
      pd = tx_data;
      pr = tx_ready;
    end
  end

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (rx.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_bytes_arrived"}, {31'd0, rx.size() >= n}, 32'd1);
  endtask

  task automatic cmp_frames(input int nfr, input string tag);
    for (int f = 0; f < nfr; f++)
      for (int k = 0; k < NB; k++)
        chk($sformatf("%s_f%0d_b%0d", tag, f, k), (f * NB + k < rx.size()) ? {24'd0, rx[f * NB + k]} : 32'h100, {24'd0, exp_f[k]});
    chk({tag, "_len"}, rx.size(), nfr * NB);
  endtask

  task automatic scan(input string tag, input logic [3:0] m, input bit lat);
    int ev [$];
    cfg_mask = m;
    build();
    rx = {};
    visits = {};
    for (int i = 0; i < NPAIR; i++) if (m[i]) ev.push_back(i);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    if (lat) begin
      chk({tag, "_busy_n1"}, {31'd0, busy}, 32'd1);
      chk({tag, "_start_n1"}, {31'd0, meas_start}, 32'd0);
      tick(1);
      chk({tag, "_sel_n2"}, {30'd0, pair_sel}, ev[0]);
      chk({tag, "_start_n2"}, {31'd0, meas_start}, 32'd0);
      tick(1);
      chk({tag, "_start_n3"}, {31'd0, meas_start}, 32'd1);
    end
    wait_bytes(NB, 20000, tag);
    tick(3);
    cmp_frames(1, tag);
    chk({tag, "_nvisits"}, visits.size(), ev.size());
    for (int i = 0; i < ev.size() && i < visits.size(); i++)
      chk($sformatf("%s_visit%0d", tag, i), visits[i], ev[i]);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < NPAIR; i++) begin
      ang[i] = '0;
      dly[i] = 10;
    end
    tick(3);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_meas_start", {31'd0, meas_start}, 32'd0);
    chk("rst_pair_sel", {30'd0, pair_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_to_err", {31'd0, to_err}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    // trig with an empty mask does nothing
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(3);
    chk("mask0_busy", {31'd0, busy}, 32'd0);
    // T1
    ang[0] = 16'd30; ang[1] = -16'sd45; ang[2] = 16'd0; ang[3] = 16'd90;
    scan("t1", 4'hF, 1'b1);
    chk("t1_to_err", {31'd0, to_err}, 32'd0);
    // T2
    ang[0] = 16'd12; ang[2] = -16'sd7; ang[1] = 16'h1234; ang[3] = 16'h4321;
    scan("t2", 4'b0101, 1'b1);
    // T3
    dly[1] = 100000;
    scan("t3", 4'hF, 1'b0);
    chk("t3_to_err", {31'd0, to_err}, 32'd1);
    // T4: 99 lands on the timeout cycle, 100 is one past it
    dly[0] = 5; dly[1] = 20; dly[2] = 99; dly[3] = 100;
    scan("t4", 4'hF, 1'b0);
    // T5
    rdy_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NPAIR; i++) begin
        ang[i] = 16'($urandom);
        dly[i] = $urandom_range(0, 120);
      end
      scan($sformatf("t5_%0d", r), 4'($urandom_range(1, 15)), 1'b1);
    end
    // T6
    rdy_mode = 1;
    for (int i = 0; i < NPAIR; i++) begin
      ang[i] = 16'($urandom);
      dly[i] = $urandom_range(0, 30);
    end
    cfg_mask = 4'hF;
    build();
    rx = {};
    cfg_cont = 1'b1;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    wait_bytes(2 * NB + 3, 20000, "t6_mid3");
    cfg_cont = 1'b0;
    wait_bytes(3 * NB, 20000, "t6_all");
    tick(60);
    cmp_frames(3, "t6");
    chk("t6_idle", {31'd0, busy}, 32'd0);
    // reset while waiting on a pair
    for (int i = 0; i < NPAIR; i++) dly[i] = 100000;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(20);
    chk("wrst_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("wrst_busy", {31'd0, busy}, 32'd0);
    chk("wrst_meas_start", {31'd0, meas_start}, 32'd0);
    chk("wrst_pair_sel", {30'd0, pair_sel}, 32'd0);
    chk("wrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("wrst_to_err", {31'd0, to_err}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < NPAIR; i++) begin
      ang[i] = 16'($urandom);
      dly[i] = 10;
    end
    scan("restart", 4'hF, 1'b1);
    // reset in the middle of a stalled frame
    rdy_mode = 0;
    dly[0] = 3;
    cfg_mask = 4'b0001;
    rx = {};
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    t = 0;
    while (!tx_valid && t < 500) begin
      tick(1);
      t++;
    end
    chk("frst_hdr", {24'd0, tx_data}, 32'hA5);
    tick(5);
    rst_n = 1'b0;
    tick(1);
    chk("frst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("frst_tx_data", {24'd0, tx_data}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    rdy_mode = 1;
    tick(5);
    chk("frst_no_bytes", rx.size(), 32'd0);
    chk("frst_idle", {31'd0, busy}, 32'd0);
    scan("post", 4'b1010, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
